// File: rtl/screen_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : screen_flow_ctrl
// Description : Top-level screen sequencer for Piano Tiles. Runs the
//               TITLE -> PLAY -> GAME OVER flow, drives the shared
//               full-screen sprite ROM address from the scan position,
//               times the game-over blink/hold and muxes the final pixel.
// Ports       : i_clk, i_rst      - clock, async active-high reset
//               xx, yy, aactive   - scan position / visible-area flag
//               start_btn         - debounced start button (level)
//               game_over         - end-of-game flag from game logic
//               play_pixel        - gameplay renderer pixel
//               rom_data          - sprite ROM word (1-cycle registered)
//               rom_addr          - sprite ROM address
//               pix_out           - final pixel (3 cycles after scan input)
//               sprite_on         - pix_out is sourced from the ROM
//               play_enable       - high only in PLAY
//               state             - 00 TITLE, 01 PLAY, 10 GO_BLINK, 11 GO_HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module screen_flow_ctrl #(
   parameter int unsigned SPR_X           = 80,
   parameter int unsigned SPR_Y           = 60,
   parameter int unsigned SPR_W           = 480,
   parameter int unsigned SPR_H           = 360,
   parameter int unsigned GO_BASE         = 172800,
   parameter int unsigned TICK_Y          = 480,
   parameter int unsigned BLINK_FRAMES    = 15,
   parameter int unsigned BLINK_COUNT     = 6,
   parameter int unsigned HOLD_MIN_FRAMES = 60,
   parameter logic [7:0]  BG_COLOR        = 8'h00
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [9:0]  xx,
   input  logic [9:0]  yy,
   input  logic        aactive,
   input  logic        start_btn,
   input  logic        game_over,
   input  logic [7:0]  play_pixel,
   input  logic [7:0]  rom_data,
   output logic [18:0] rom_addr,
   output logic [7:0]  pix_out,
   output logic        sprite_on,
   output logic        play_enable,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_TITLE    = 2'b00,
      ST_PLAY     = 2'b01,
      ST_GO_BLINK = 2'b10,
      ST_GO_HOLD  = 2'b11
   } state_t;

   localparam int BFW = $clog2(BLINK_FRAMES + 1);
   localparam int TGW = $clog2(BLINK_COUNT + 1);
   localparam int HDW = $clog2(HOLD_MIN_FRAMES + 1);

   localparam logic [10:0]    c_x_lo       = 11'(SPR_X);
   localparam logic [10:0]    c_x_hi       = 11'(SPR_X + SPR_W);
   localparam logic [10:0]    c_y_lo       = 11'(SPR_Y);
   localparam logic [10:0]    c_y_hi       = 11'(SPR_Y + SPR_H);
   localparam logic [9:0]     c_tick_y     = 10'(TICK_Y);
   localparam logic [18:0]    c_spr_x      = 19'(SPR_X);
   localparam logic [18:0]    c_spr_y      = 19'(SPR_Y);
   localparam logic [18:0]    c_spr_w      = 19'(SPR_W);
   localparam logic [18:0]    c_go_base    = 19'(GO_BASE);
   localparam logic [BFW-1:0] c_blink_last = BFW'(BLINK_FRAMES - 1);
   localparam logic [TGW-1:0] c_tog_last   = TGW'(BLINK_COUNT - 1);
   localparam logic [HDW-1:0] c_hold_min   = HDW'(HOLD_MIN_FRAMES);

   // ------------------------------------------------------------------
   // Frame tick and start-request edge detectors
   // ------------------------------------------------------------------
   logic r_y_is_tick, r_y_is_tick_d;
   logic r_start_d1, r_start_d2;
   logic w_tick, w_start_req;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_y_is_tick   <= 1'b0;
         r_y_is_tick_d <= 1'b0;
         r_start_d1    <= 1'b0;
         r_start_d2    <= 1'b0;
      end else begin
         r_y_is_tick   <= (yy == c_tick_y);
         r_y_is_tick_d <= r_y_is_tick;
         r_start_d1    <= start_btn;
         r_start_d2    <= r_start_d1;
      end
   end

   // Edge of the registered compare: one tick per frame even if yy
   // stays on TICK_Y for many clocks.
   assign w_tick      = r_y_is_tick & ~r_y_is_tick_d;
   assign w_start_req = r_start_d1 & ~r_start_d2;

   // ------------------------------------------------------------------
   // Screen FSM
   // ------------------------------------------------------------------
   state_t         r_state, w_state_nxt;
   logic [BFW-1:0] r_blink_frm, w_blink_nxt;
   logic [TGW-1:0] r_tog_cnt, w_tog_nxt;
   logic [HDW-1:0] r_hold_cnt, w_hold_nxt;
   logic           r_vis, w_vis_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_TITLE;
         r_blink_frm <= '0;
         r_tog_cnt   <= '0;
         r_hold_cnt  <= '0;
         r_vis       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_blink_frm <= w_blink_nxt;
         r_tog_cnt   <= w_tog_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_vis       <= w_vis_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_blink_nxt = r_blink_frm;
      w_tog_nxt   = r_tog_cnt;
      w_hold_nxt  = r_hold_cnt;
      w_vis_nxt   = r_vis;

      // Any state change clears the counters and makes the sprite visible.
      case (r_state)
         ST_TITLE: begin
            if (w_start_req) begin
               w_state_nxt = ST_PLAY;
               w_blink_nxt = '0;
               w_tog_nxt   = '0;
               w_hold_nxt  = '0;
               w_vis_nxt   = 1'b1;
            end
         end
         ST_PLAY: begin
            // game_over has priority over a coincident start request.
            if (game_over) begin
               w_state_nxt = ST_GO_BLINK;
               w_blink_nxt = '0;
               w_tog_nxt   = '0;
               w_hold_nxt  = '0;
               w_vis_nxt   = 1'b1;
            end
         end
         ST_GO_BLINK: begin
            if (w_tick) begin
               if (r_blink_frm == c_blink_last) begin
                  w_blink_nxt = '0;
                  w_vis_nxt   = ~r_vis;
                  if (r_tog_cnt == c_tog_last) begin
                     w_state_nxt = ST_GO_HOLD;
                     w_tog_nxt   = '0;
                     w_hold_nxt  = '0;
                     w_vis_nxt   = 1'b1;
                  end else begin
                     w_tog_nxt = r_tog_cnt + 1'b1;
                  end
               end else begin
                  w_blink_nxt = r_blink_frm + 1'b1;
               end
            end
         end
         ST_GO_HOLD: begin
            // Early start requests simply fall through and are lost.
            if (w_start_req && (r_hold_cnt == c_hold_min)) begin
               w_state_nxt = ST_TITLE;
               w_blink_nxt = '0;
               w_tog_nxt   = '0;
               w_hold_nxt  = '0;
               w_vis_nxt   = 1'b1;
            end else if (w_tick && (r_hold_cnt != c_hold_min)) begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_TITLE;
         end
      endcase
   end

   assign state       = r_state;
   assign play_enable = (r_state == ST_PLAY);

   // ------------------------------------------------------------------
   // S1: window decode and ROM address
   // ------------------------------------------------------------------
   logic        w_in_win;
   logic [18:0] w_dx, w_dy, w_base, w_addr;

   assign w_in_win = ({1'b0, xx} >= c_x_lo) && ({1'b0, xx} < c_x_hi) &&
                     ({1'b0, yy} >= c_y_lo) && ({1'b0, yy} < c_y_hi);
   assign w_dx     = 19'(xx) - c_spr_x;
   assign w_dy     = 19'(yy) - c_spr_y;
   assign w_base   = (r_state == ST_TITLE) ? 19'd0 : c_go_base;
   assign w_addr   = w_base + w_dx + (w_dy * c_spr_w);

   logic       r_in_win_s1, r_act_s1, r_vis_s1;
   logic [1:0] r_state_s1;
   logic [7:0] r_pix_s1;
   logic       r_in_win_s2, r_act_s2, r_vis_s2;
   logic [1:0] r_state_s2;
   logic [7:0] r_pix_s2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rom_addr    <= '0;
         r_in_win_s1 <= 1'b0;
         r_act_s1    <= 1'b0;
         r_vis_s1    <= 1'b0;
         r_state_s1  <= 2'b00;
         r_pix_s1    <= '0;
      end else begin
         // Address is frozen outside the window and throughout PLAY.
         if (w_in_win && (r_state != ST_PLAY)) begin
            rom_addr <= w_addr;
         end
         r_in_win_s1 <= w_in_win;
         r_act_s1    <= aactive;
         r_vis_s1    <= r_vis;
         r_state_s1  <= r_state;
         r_pix_s1    <= play_pixel;
      end
   end

   // ------------------------------------------------------------------
   // S2: alignment with the registered ROM output
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_in_win_s2 <= 1'b0;
         r_act_s2    <= 1'b0;
         r_vis_s2    <= 1'b0;
         r_state_s2  <= 2'b00;
         r_pix_s2    <= '0;
      end else begin
         r_in_win_s2 <= r_in_win_s1;
         r_act_s2    <= r_act_s1;
         r_vis_s2    <= r_vis_s1;
         r_state_s2  <= r_state_s1;
         r_pix_s2    <= r_pix_s1;
      end
   end

   // ------------------------------------------------------------------
   // S3: output mux
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pix_out   <= '0;
         sprite_on <= 1'b0;
      end else if (!r_act_s2) begin
         pix_out   <= '0;
         sprite_on <= 1'b0;
      end else if (r_state_s2 == ST_PLAY) begin
         pix_out   <= r_pix_s2;
         sprite_on <= 1'b0;
      end else if (r_in_win_s2 && ((r_state_s2 == ST_TITLE) || r_vis_s2)) begin
         pix_out   <= rom_data;
         sprite_on <= 1'b1;
      end else begin
         pix_out   <= BG_COLOR;
         sprite_on <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_screen_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_flow_ctrl
// Description : Directed, table-driven bench for screen_flow_ctrl with a
//               behavioural 1-cycle sprite ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_flow_ctrl;

   logic        clk;
   logic        rst;
   logic [9:0]  xx, yy;
   logic        aactive, start_btn, game_over;
   logic [7:0]  play_pixel, rom_data;
   logic [18:0] rom_addr;
   logic [7:0]  pix_out;
   logic        sprite_on, play_enable;
   logic [1:0]  state;

   int n_tests;
   int n_fail;

   screen_flow_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .xx          (xx),
      .yy          (yy),
      .aactive     (aactive),
      .start_btn   (start_btn),
      .game_over   (game_over),
      .play_pixel  (play_pixel),
      .rom_data    (rom_data),
      .rom_addr    (rom_addr),
      .pix_out     (pix_out),
      .sprite_on   (sprite_on),
      .play_enable (play_enable),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sprite ROM contents: a scrambled function of the address.
   function automatic logic [7:0] rom_fn(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b10101};
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold yy on the tick line for several clocks, then restore the scan.
   task automatic tick();
      logic [9:0] sv;
      sv = yy;
      yy = 10'd480;
      cyc(3);
      yy = sv;
      cyc(4);
   endtask

   task automatic press();
      start_btn = 1'b1;
      cyc(3);
      start_btn = 1'b0;
      cyc(2);
   endtask

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        act;
      logic        exp_spr;
      logic [18:0] exp_addr;
   } vec_t;

   vec_t vecs[10];

   localparam logic [18:0] GO_BASE = 19'd172800;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_pix;
      int         tg;
      logic       ev;

      n_tests = 0;
      n_fail  = 0;

      vecs[0] = '{x:10'd80,  y:10'd60,  act:1'b1, exp_spr:1'b1, exp_addr:19'd0};
      vecs[1] = '{x:10'd79,  y:10'd60,  act:1'b1, exp_spr:1'b0, exp_addr:19'd0};
      vecs[2] = '{x:10'd81,  y:10'd60,  act:1'b1, exp_spr:1'b1, exp_addr:19'd1};
      vecs[3] = '{x:10'd80,  y:10'd61,  act:1'b1, exp_spr:1'b1, exp_addr:19'd480};
      vecs[4] = '{x:10'd559, y:10'd419, act:1'b1, exp_spr:1'b1, exp_addr:19'd172799};
      vecs[5] = '{x:10'd560, y:10'd419, act:1'b1, exp_spr:1'b0, exp_addr:19'd172799};
      vecs[6] = '{x:10'd559, y:10'd420, act:1'b1, exp_spr:1'b0, exp_addr:19'd172799};
      vecs[7] = '{x:10'd300, y:10'd200, act:1'b0, exp_spr:1'b0, exp_addr:19'd67420};
      vecs[8] = '{x:10'd300, y:10'd200, act:1'b1, exp_spr:1'b1, exp_addr:19'd67420};
      vecs[9] = '{x:10'd80,  y:10'd59,  act:1'b1, exp_spr:1'b0, exp_addr:19'd67420};

      rst        = 1'b1;
      xx         = '0;
      yy         = '0;
      aactive    = 1'b0;
      start_btn  = 1'b0;
      game_over  = 1'b0;
      play_pixel = '0;

      #1;
      chk("reset state", 32'(state), 32'd0);
      chk("reset pix_out", 32'(pix_out), 32'd0);
      chk("reset sprite_on", 32'(sprite_on), 32'd0);
      chk("reset rom_addr", 32'(rom_addr), 32'd0);
      chk("reset play_enable", 32'(play_enable), 32'd0);
      cyc(2);
      rst = 1'b0;
      cyc(1);

      // ---------------- TITLE window vectors ----------------
      for (int i = 0; i < 10; i++) begin
         xx      = vecs[i].x;
         yy      = vecs[i].y;
         aactive = vecs[i].act;
         cyc(1);
         chk($sformatf("title addr v%0d", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
         cyc(2);
         exp_pix = vecs[i].exp_spr ? rom_fn(vecs[i].exp_addr) : 8'h00;
         chk($sformatf("title pix v%0d", i), 32'(pix_out), 32'(exp_pix));
         chk($sformatf("title spr v%0d", i), 32'(sprite_on), 32'(vecs[i].exp_spr));
      end

      // ---------------- start held 100 cycles ----------------
      start_btn = 1'b1;
      cyc(100);
      chk("held start state", 32'(state), 32'd1);
      chk("held start play_enable", 32'(play_enable), 32'd1);
      start_btn = 1'b0;
      cyc(2);

      // ---------------- PLAY pixel latency ----------------
      xx         = 10'd100;
      yy         = 10'd100;
      play_pixel = 8'hA5;
      cyc(2);
      chk("play pix before latency", 32'(pix_out), 32'd0);
      cyc(1);
      chk("play pix latency 3", 32'(pix_out), 32'hA5);
      chk("play sprite_on", 32'(sprite_on), 32'd0);
      chk("play addr held", 32'(rom_addr), 32'd67420);
      play_pixel = 8'h3C;
      cyc(3);
      chk("play pix second", 32'(pix_out), 32'h3C);

      // ---------------- game_over beats start ----------------
      game_over = 1'b1;
      start_btn = 1'b1;
      cyc(1);
      game_over = 1'b0;
      cyc(2);
      chk("go beats start", 32'(state), 32'd2);
      start_btn = 1'b0;
      chk("blink play_enable", 32'(play_enable), 32'd0);

      // ---------------- GO_BLINK timing ----------------
      xx = 10'd300;
      yy = 10'd200;
      cyc(1);
      for (int t = 1; t <= 90; t++) begin
         tick();
         tg = t / 15;
         ev = (tg % 2) == 0;
         chk($sformatf("blink state t%0d", t), 32'(state), (t >= 90) ? 32'd3 : 32'd2);
         chk($sformatf("blink spr t%0d", t), 32'(sprite_on), 32'(ev));
         exp_pix = ev ? rom_fn(GO_BASE + 19'd67420) : 8'h00;
         chk($sformatf("blink pix t%0d", t), 32'(pix_out), 32'(exp_pix));
      end

      // ---------------- GO_HOLD ----------------
      for (int t = 1; t <= 30; t++) tick();
      press();
      chk("hold early start t30", 32'(state), 32'd3);
      for (int t = 31; t <= 59; t++) tick();
      press();
      chk("hold early start t59", 32'(state), 32'd3);

      xx = 10'd559;
      yy = 10'd419;
      cyc(1);
      chk("hold addr last pixel", 32'(rom_addr), 32'(GO_BASE + 19'd172799));
      cyc(2);
      chk("hold spr last pixel", 32'(sprite_on), 32'd1);
      chk("hold pix last pixel", 32'(pix_out), 32'(rom_fn(GO_BASE + 19'd172799)));
      xx = 10'd560;
      cyc(1);
      chk("hold addr x560", 32'(rom_addr), 32'(GO_BASE + 19'd172799));
      cyc(2);
      chk("hold spr x560", 32'(sprite_on), 32'd0);
      chk("hold pix x560", 32'(pix_out), 32'd0);
      xx = 10'd300;
      yy = 10'd200;
      cyc(3);

      tick();
      press();
      chk("hold start t60", 32'(state), 32'd0);
      cyc(3);
      chk("title base addr", 32'(rom_addr), 32'd67420);
      chk("title base pix", 32'(pix_out), 32'(rom_fn(19'd67420)));

      // ---------------- async reset mid GO_BLINK ----------------
      press();
      chk("reenter play", 32'(state), 32'd1);
      game_over = 1'b1;
      cyc(1);
      game_over = 1'b0;
      chk("reenter blink", 32'(state), 32'd2);
      for (int t = 1; t <= 5; t++) tick();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst state", 32'(state), 32'd0);
      chk("async rst pix", 32'(pix_out), 32'd0);
      chk("async rst spr", 32'(sprite_on), 32'd0);
      chk("async rst addr", 32'(rom_addr), 32'd0);
      chk("async rst play_enable", 32'(play_enable), 32'd0);
      cyc(2);
      rst = 1'b0;
      cyc(3);
      chk("post rst title spr", 32'(sprite_on), 32'd1);
      chk("post rst title pix", 32'(pix_out), 32'(rom_fn(19'd67420)));

      press();
      game_over = 1'b1;
      cyc(1);
      game_over = 1'b0;
      for (int t = 1; t <= 14; t++) tick();
      chk("post rst blink t14 spr", 32'(sprite_on), 32'd1);
      tick();
      chk("post rst blink t15 spr", 32'(sprite_on), 32'd0);
      chk("post rst blink t15 state", 32'(state), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
